// File: rtl/type1_node_dec_pkg.sv
// Shared definitions for the type-1 repetition node decoder: LLR width default,
// accumulator width derivation and FSM state encodings.
package type1_node_dec_pkg;

    localparam int unsigned LLR_W_DEF = 6;

    // Wide enough for LANES*MAX_BEATS/GROUPS full-scale LLRs, so the sum never wraps.
    function automatic int unsigned acc_width(input int unsigned llr_w,
                                              input int unsigned lanes,
                                              input int unsigned groups,
                                              input int unsigned max_beats);
        return llr_w + $clog2(lanes * max_beats / groups);
    endfunction

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAcc  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/type1_grp_sum.sv
// Combinational per-beat reduction: sign-extends each lane and sums it into
// group (lane mod GROUPS). Lane 0 sits in the MSBs; group 0 output in the MSBs.
module type1_grp_sum #(
    parameter int unsigned LLR_W  = 6,
    parameter int unsigned LANES  = 8,
    parameter int unsigned GROUPS = 2,
    parameter int unsigned ACC_W  = 10
) (
    input  logic [LANES*LLR_W-1:0]  llr,
    output logic [GROUPS*ACC_W-1:0] sums
);

    logic [ACC_W-1:0] acc [GROUPS];
    logic [LLR_W-1:0] lane;

    always_comb begin
        for (int g = 0; g < GROUPS; g++) begin
            acc[g] = '0;
        end
        lane = '0;
        for (int k = 0; k < LANES; k++) begin
            lane = llr[(LANES-1-k)*LLR_W +: LLR_W];
            acc[k % GROUPS] = acc[k % GROUPS] + {{(ACC_W-LLR_W){lane[LLR_W-1]}}, lane};
        end
        for (int g = 0; g < GROUPS; g++) begin
            sums[(GROUPS-1-g)*ACC_W +: ACC_W] = acc[g];
        end
    end

endmodule

// File: rtl/type1_node_dec.sv
// Type-1 repetition node decoder: accumulates interleaved LLR groups over up to
// MAX_BEATS beats and reports per-group hard decisions. Define TYPE1_SUM_OUT_EN to expose sums.
module type1_node_dec
    import type1_node_dec_pkg::*;
#(
    parameter int unsigned LLR_W     = LLR_W_DEF,
    parameter int unsigned LANES     = 8,
    parameter int unsigned GROUPS    = 2,
    parameter int unsigned MAX_BEATS = 4,
    localparam int unsigned ACC_W    = acc_width(LLR_W, LANES, GROUPS, MAX_BEATS),
    localparam int unsigned CNT_W    = $clog2(MAX_BEATS) + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*LLR_W-1:0]       in_llr,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [GROUPS-1:0]            dec,
    output logic [LANES*MAX_BEATS-1:0]   bit_out,
    output logic [CNT_W-1:0]             nbeats,
`ifdef TYPE1_SUM_OUT_EN
    output logic                         ovf,
    output logic [GROUPS*ACC_W-1:0]      sum_out
`else
    output logic                         ovf
`endif
);

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_BEATS);

    state_e                  state_q, state_d;
    logic [GROUPS*ACC_W-1:0] beat_sum;
    logic [ACC_W-1:0]        acc_q [GROUPS];
    logic [ACC_W-1:0]        acc_d [GROUPS];
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    discard_q, discard_d;
    logic [GROUPS-1:0]       dec_q, dec_d;
    logic [CNT_W-1:0]        nbeats_q;
    logic                    ovf_q;
    logic                    accept, fold, start, done;

    type1_grp_sum #(
        .LLR_W  (LLR_W),
        .LANES  (LANES),
        .GROUPS (GROUPS),
        .ACC_W  (ACC_W)
    ) u_grp_sum (
        .llr  (in_llr),
        .sums (beat_sum)
    );

    assign in_ready  = (state_q != StDone);
    assign out_valid = (state_q == StDone);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        discard_d = discard_q;
        acc_d     = acc_q;
        fold      = 1'b0;
        start     = 1'b0;
        done      = 1'b0;
        dec_d     = '0;
        unique case (state_q)
            StIdle: begin
                // Tail of an overflowed node is swallowed here until its in_last.
                if (accept && discard_q) begin
                    if (in_last) discard_d = 1'b0;
                end else if (accept) begin
                    fold  = 1'b1;
                    start = 1'b1;
                end
            end
            StAcc:   fold = accept;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (fold) begin
            cnt_d = start ? CNT_W'(1) : cnt_q + CNT_W'(1);
            for (int g = 0; g < GROUPS; g++) begin
                acc_d[g] = (start ? '0 : acc_q[g]) + beat_sum[(GROUPS-1-g)*ACC_W +: ACC_W];
            end
            done    = in_last || (cnt_d == MaxCnt);
            state_d = done ? StDone : StAcc;
            if (done) discard_d = !in_last;
        end
        for (int g = 0; g < GROUPS; g++) begin
            dec_d[GROUPS-1-g] = acc_d[g][ACC_W-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            discard_q <= 1'b0;
            dec_q     <= '0;
            nbeats_q  <= '0;
            ovf_q     <= 1'b0;
            for (int g = 0; g < GROUPS; g++) acc_q[g] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            discard_q <= discard_d;
            acc_q     <= acc_d;
            if (done) begin
                dec_q    <= dec_d;
                nbeats_q <= cnt_d;
                ovf_q    <= !in_last;
            end
        end
    end

    // Bit i carries dec[i mod GROUPS] for the first nbeats*LANES positions.
    always_comb begin
        bit_out = '0;
        for (int i = 0; i < LANES*MAX_BEATS; i++) begin
            if (i < int'(nbeats_q) * int'(LANES)) bit_out[i] = dec_q[i % GROUPS];
        end
    end

    assign dec    = dec_q;
    assign nbeats = nbeats_q;
    assign ovf    = ovf_q;

`ifdef TYPE1_SUM_OUT_EN
    logic [GROUPS*ACC_W-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = '0;
        for (int g = 0; g < GROUPS; g++) sum_d[(GROUPS-1-g)*ACC_W +: ACC_W] = acc_d[g];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    sum_q <= '0;
        else if (done) sum_q <= sum_d;
    end

    assign sum_out = sum_q;
`endif

endmodule

// File: tb/tb_type1_node_dec.sv
// Directed self-checking bench for type1_node_dec at default parameters
// (LLR_W=6, LANES=8, GROUPS=2, MAX_BEATS=4).
module tb_type1_node_dec;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_llr;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  dec;
    logic [31:0] bit_out;
    logic [2:0]  nbeats;
    logic        ovf;
`ifdef TYPE1_SUM_OUT_EN
    logic [19:0] sum_out;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    type1_node_dec dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_llr    (in_llr),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dec       (dec),
        .bit_out   (bit_out),
        .nbeats    (nbeats),
`ifdef TYPE1_SUM_OUT_EN
        .ovf       (ovf),
        .sum_out   (sum_out)
`else
        .ovf       (ovf)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Lane 0 in the MSBs, 6-bit two's complement per lane.
    function automatic logic [47:0] pack8(input int v0, input int v1, input int v2, input int v3,
                                          input int v4, input int v5, input int v6, input int v7);
        int          v [8];
        logic [31:0] t;
        logic [47:0] r;
        v = '{v0, v1, v2, v3, v4, v5, v6, v7};
        r = '0;
        for (int k = 0; k < 8; k++) begin
            t = v[k];
            r[(7-k)*6 +: 6] = t[5:0];
        end
        return r;
    endfunction

    function automatic logic [47:0] eo(input int e, input int o);
        return pack8(e, o, e, o, e, o, e, o);
    endfunction

    // Returns just after the accepting clock edge.
    task automatic send(input logic [47:0] llr, input logic last);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_llr   = llr;
        in_last  = last;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) check("send_timeout", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_ack_out_valid", {63'd0, out_valid}, 64'd0);
        check("post_ack_in_ready", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_llr    = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #23;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_dec", {62'd0, dec}, 64'd0);
        check("rst_bit_out", {32'd0, bit_out}, 64'd0);
        check("rst_nbeats", {61'd0, nbeats}, 64'd0);
        check("rst_ovf", {63'd0, ovf}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Single beat: group0 = +20, group1 = -12.
        send(eo(5, -3), 1'b1);
        check("t1_out_valid", {63'd0, out_valid}, 64'd1);
        check("t1_dec", {62'd0, dec}, 64'd1);
        check("t1_nbeats", {61'd0, nbeats}, 64'd1);
        check("t1_bit_out", {32'd0, bit_out}, 64'h55);
        check("t1_ovf", {63'd0, ovf}, 64'd0);
        check("t1_in_ready", {63'd0, in_ready}, 64'd0);
`ifdef TYPE1_SUM_OUT_EN
        check("t1_sum_out", {44'd0, sum_out}, {44'd0, 10'd20, 10'h3F4});
`endif
        consume();

        // Four beats: group0 = -16, group1 = +32.
        for (int b = 0; b < 4; b++) send(eo(-1, 2), b == 3);
        check("t2_dec", {62'd0, dec}, 64'd2);
        check("t2_nbeats", {61'd0, nbeats}, 64'd4);
        check("t2_bit_out", {32'd0, bit_out}, 64'hAAAAAAAA);
        check("t2_ovf", {63'd0, ovf}, 64'd0);
        consume();

        // Group0 sums to exactly zero, group1 negative.
        send(pack8(4, -1, -4, -1, 4, -1, -4, -1), 1'b1);
        check("t3_dec", {62'd0, dec}, 64'd1);
        check("t3_bit_out", {32'd0, bit_out}, 64'h55);
        consume();

        // Overflow: no in_last within four beats.
        for (int b = 0; b < 4; b++) send(eo(2, -1), 1'b0);
        check("t4_out_valid", {63'd0, out_valid}, 64'd1);
        check("t4_ovf", {63'd0, ovf}, 64'd1);
        check("t4_nbeats", {61'd0, nbeats}, 64'd4);
        check("t4_dec", {62'd0, dec}, 64'd1);
        check("t4_bit_out", {32'd0, bit_out}, 64'h55555555);
        // Backpressure: hold for five cycles.
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("hold_out_valid", {63'd0, out_valid}, 64'd1);
            check("hold_in_ready", {63'd0, in_ready}, 64'd0);
            check("hold_dec", {62'd0, dec}, 64'd1);
            check("hold_bit_out", {32'd0, bit_out}, 64'h55555555);
            check("hold_nbeats", {61'd0, nbeats}, 64'd4);
            check("hold_ovf", {63'd0, ovf}, 64'd1);
        end
        consume();
        // Fifth beat carries in_last and is dropped.
        send(eo(-7, 7), 1'b1);
        check("t4_discard_no_out", {63'd0, out_valid}, 64'd0);
        check("t4_discard_in_ready", {63'd0, in_ready}, 64'd1);
        send(eo(-3, 5), 1'b1);
        check("t4_next_dec", {62'd0, dec}, 64'd2);
        check("t4_next_nbeats", {61'd0, nbeats}, 64'd1);
        check("t4_next_bit_out", {32'd0, bit_out}, 64'hAA);
        check("t4_next_ovf", {63'd0, ovf}, 64'd0);
        consume();

        // Reset in the middle of a four-beat node.
        send(eo(1, 1), 1'b0);
        send(eo(1, 1), 1'b0);
        rst_n = 1'b0;
        #7;
        check("t5_rst_nbeats", {61'd0, nbeats}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("t5_no_out_valid", {63'd0, out_valid}, 64'd0);
        end
        send(eo(5, -3), 1'b1);
        check("t5_out_valid", {63'd0, out_valid}, 64'd1);
        check("t5_dec", {62'd0, dec}, 64'd1);
        check("t5_nbeats", {61'd0, nbeats}, 64'd1);
        check("t5_bit_out", {32'd0, bit_out}, 64'h55);
        consume();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
